// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: shared constants and types for the seven-segment scan controller
package seg_scan_ctrl_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef logic [DIG_W-1:0] dig_t;
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low a..g segment pattern
module hex_to_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  // full 0-F glyph table, seg_o[0]=a ... seg_o[6]=g, low lights the segment
  always_comb begin
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed seven-segment scanner with frame-aligned value updates
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [2:0]  sel,
  output logic [6:0]  seg,
  output logic        upd
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  dig_t          d_q, d_d;
  logic [15:0]   sh_q, sh_d, disp_q, disp_d;
  logic          pend_q, pend_d, upd_q, upd_d;
  logic          tick, frame;
  logic [15:0]   hi;
  logic [6:0]    hex_seg;
  // next state: prescaler wrap, digit advance, and shadow-to-display handoff only at frame boundaries
  always_comb begin
    tick   = cnt_q == CW'(REFRESH_DIV - 1);
    frame  = tick && d_q == dig_t'(NUM_DIGITS - 1);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    d_d    = tick ? d_q + 1'b1 : d_q;
    upd_d  = frame && pend_q;
    disp_d = upd_d ? sh_q : disp_q;
    sh_d   = load ? value : sh_q;
    pend_d = load || (pend_q && !frame);
  end
  // state registers; reset discards any pending value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      d_q    <= '0;
      sh_q   <= '0;
      disp_q <= '0;
      pend_q <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      sh_q   <= sh_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      upd_q  <= upd_d;
    end
  end
  // hi holds the current digit and every higher one, so a zero hi means a leading zero
  assign hi = disp_q >> {d_q, 2'b00};
  hex_to_seg u_hex (
    .hex_i (hi[3:0]),
    .seg_o (hex_seg)
  );
  assign sel = {1'b0, d_q};
  assign seg = (blank_lz && d_q != '0 && hi == '0) ? SEG_BLANK : hex_seg;
  assign upd = upd_q;
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port value  input  16  four hex nibbles; [3:0]=digit 0 ... [15:12]=digit 3.
REQ-005 SHALL have port load  input  1  one-cycle request to capture value.
REQ-006 SHALL have port blank_lz  input  1  level; enables leading-zero blanking.
REQ-007 SHALL have port sel  output  3  digit select to the downstream 3-to-8 anode decoder; sel[2] tied 0.
REQ-008 SHALL have port seg  output  7  cathodes, active-low; seg[0]=a ... seg[6]=g.
REQ-009 SHALL have port upd  output  1  one-cycle pulse when a new value reaches the display.

Function
REQ-010 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted in the cycle where count == REFRESH_DIV-1.
REQ-011 2-bit digit index d SHALL increment on tick, wrapping 3->0; sel = {0,d}, updated the cycle after tick.
REQ-012 Frame boundary SHALL be defined as a tick with d==3.
REQ-013 load SHALL write value into shadow register sh and set pending; a load while pending already set SHALL overwrite sh (latest wins).
REQ-014 At a frame boundary with pending set, disp SHALL take sh, pending SHALL clear, and upd SHALL pulse for exactly one cycle, coincident with d becoming 0.
REQ-015 Load coincident with a pending frame boundary: disp takes the old sh; the new value goes to sh and pending stays set (applied at the next boundary).
REQ-016 Load coincident with a boundary while not pending: the new value goes to sh, pending sets, disp is unchanged, and upd stays low.
REQ-017 disp SHALL change only at frame boundaries, so the display never shows a partially updated value.
REQ-018 seg SHALL be derived from registered d and disp with no extra latency relative to sel; sel and seg change in the same cycle.
REQ-019 Encoding SHALL be full hex 0-F (active-low); e.g. 0->0x40, 1->0x79, 5->0x12, 8->0x00, A->0x08, F->0x0E.
REQ-020 With blank_lz=1, digit k (k=3..1) SHALL output 0x7F when its nibble and all higher nibbles are zero; digit 0 is never blanked.
REQ-021 blank_lz SHALL take effect combinationally on the current digit.

Reset
REQ-022 While rst=1: prescaler=0, d=0, disp=0, sh=0, pending=0, upd=0, regardless of clk.
REQ-023 Resulting outputs: sel=0, seg=0x40, upd=0; reset mid-scan or mid-pending discards the pending value.
REQ-024 First tick after reset release SHALL occur REFRESH_DIV cycles after the first active edge.

Structure
REQ-025 Shared package SHALL hold SEG_BLANK (7'h7F), NUM_DIGITS (4), and the digit-index width.
REQ-026 Hex-to-segment encoding SHALL be a sub-module, hex_to_seg (4-bit in, 7-bit active-low out, combinational).
REQ-027 Prescaler, digit counter, shadow/pending logic and blanking SHALL stay in seg_scan_ctrl.

Verification (REFRESH_DIV=4)
REQ-028 Free-run after reset -> sel steps 0,1,2,3,0, changing every 4 cycles; seg=0x40 on digit 0; upd never pulses.
REQ-029 load value=0x12AF while d=1 -> seg unchanged until the 3->0 wrap; upd pulses once; then digits 0..3 show 0x0E,0x08,0x24,0x79.
REQ-030 load 0x1111 then load 0x2222 before the boundary -> single upd; all digits show 0x24.
REQ-031 load 0x3333 (pending), then load 0x4444 in the boundary cycle -> 0x3333 is displayed with upd; 0x4444 is displayed at the next boundary with a second upd.
REQ-032 blank_lz=1, value=0x0005 -> digits 3..1 show 0x7F and digit 0 shows 0x12; value=0x0000 -> digit 0 shows 0x40; value=0x0100 -> digit 1 shows 0x40 (not blanked).
REQ-033 rst asserted at d=2 with pending set -> sel=0, seg=0x40 immediately; after release no upd occurs.
